fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter for the MAC's asynchronous FIFO. Several frame sources in the FIFO write-clock domain share the single FIFO write port. The grant is held for a whole frame so that beats from different sources never interleave. It also guards against a stalled source: a source that stalls too long mid-frame loses the grant and the abort is reported.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arb_rr_pick.sv | 45 ++++
 rtl/fifo_wr_arb.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t   : arbiter state encoding (IDLE / GRANT)
//   DEF_N_REQ     : default number of requesters
//   DEF_STALL_MAX : default idle cycles tolerated inside a granted frame
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_STALL_MAX = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin priority selector.
// Ports:
//   req_i        : request vector, one bit per source
//   last_grant_i : index of the most recently served source
//   found_o      : at least one request is asserted
//   idx_o        : first requesting index searching from last_grant_i+1, wrapping
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ID_LEN = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  req_i,
  input  logic [ID_LEN-1:0] last_grant_i,
  output logic              found_o,
  output logic [ID_LEN-1:0] idx_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] win_mask;
  logic [2*N_REQ-1:0] cand;
  int                 start;

  // The request vector is doubled so that a window of N_REQ bits starting at
  // last_grant+1 covers the wrap-around; the lowest set bit inside that window
  // is the winner, folded back modulo N_REQ.
  always_comb begin
    start    = (int'(last_grant_i) >= N_REQ - 1) ? 0 : int'(last_grant_i) + 1;
    dbl      = {req_i, req_i};
    win_mask = '0;
    for (int i = 0; i < 2 * N_REQ; i++) begin
      win_mask[i] = (i >= start) && (i < start + N_REQ);
    end
    cand    = dbl & win_mask;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < 2 * N_REQ; i++) begin
      if (cand[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = ID_LEN'(i % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter for the MAC asynchronous FIFO. The grant is
// held for a whole frame; an owner idle for STALL_MAX cycles loses the grant.
// Ports:
//   clk, srstn   : write clock, synchronous active-low reset
//   req_valid/last/data, req_ready : per-source beat interface
//   fifo_full, fifo_w_en, fifo_data : FIFO write port
//   grant_id, busy : current owner and frame-in-progress flag
//   abort        : one-cycle pulse when a frame is cut by stall timeout
// Handshake: a beat of source i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; a valid beat holds its data/last until then.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = 8,
  parameter int STALL_MAX = DEF_STALL_MAX,
  parameter int ID_LEN    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   srstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_w_en,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [ID_LEN-1:0]      grant_id,
  output logic                   busy,
  output logic                   abort
);

  localparam int                CNT_W     = $clog2(STALL_MAX + 1);
  localparam logic [ID_LEN-1:0] LAST_INIT = ID_LEN'(N_REQ - 1);
  // The abort is registered, so it trips on the cycle whose count would reach
  // STALL_MAX; the pulse then appears the cycle after that count is reached.
  localparam logic [CNT_W-1:0]  CNT_TRIP  = CNT_W'(STALL_MAX - 1);

  arb_state_t        state_q, state_d;
  logic [ID_LEN-1:0] grant_q, grant_d;
  logic [ID_LEN-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;

  logic              pick_found;
  logic [ID_LEN-1:0] pick_idx;
  logic              own_valid;
  logic              own_last;
  logic [WIDTH-1:0]  own_data;

  rr_pick #(
    .N_REQ  (N_REQ),
    .ID_LEN (ID_LEN)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .found_o      (pick_found),
    .idx_o        (pick_idx)
  );

  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[int'(grant_q) * WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    req_ready = '0;
    fifo_w_en = 1'b0;
    fifo_data = '0;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        req_ready[grant_q] = ~fifo_full;
        fifo_w_en          = own_valid & ~fifo_full;
        fifo_data          = own_data;
        if (fifo_w_en) begin
          cnt_d = '0;
          if (own_last) begin
            last_d  = grant_q;
            state_d = ARB_IDLE;
          end
        end else if (!own_valid) begin
          // Only owner silence counts; a full FIFO with a waiting beat holds.
          if (cnt_q == CNT_TRIP) begin
            abort_d = 1'b1;
            last_d  = grant_q;
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // No beat may be accepted while reset is asserted.
    if (!srstn) begin
      req_ready = '0;
      fifo_w_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_GRANT);
  assign abort    = abort_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SMAX = 16;
  localparam int IDW  = 2;

  logic           clk = 1'b0;
  logic           srstn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_w_en;
  logic [W-1:0]   fifo_data;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           abort;

  fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .STALL_MAX(SMAX)) dut (
    .clk       (clk),
    .srstn     (srstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  // Source model: per-source queue of beats {last, data}.
  logic [W:0]   sq [N][$];
  logic [N-1:0] hold;
  // Scoreboard.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           exp_gnt[$];
  int           gnt_q[$];
  int           wr_cyc_q[$];
  int           cyc, checks, failures, abort_cnt, abort_cyc, model_last;
  logic           obs_w_en, obs_busy, obs_abort, prev_busy;
  logic [N-1:0]   obs_ready;
  logic [W-1:0]   obs_data;
  logic [IDW-1:0] obs_gid;

  function automatic int pending();
    int t = 0;
    for (int i = 0; i < N; i++) t += sq[i].size();
    return t;
  endfunction

  task automatic drive();
    logic [W:0] b;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0 && !hold[i]) begin
        b = sq[i][0];
        req_valid[i]          = 1'b1;
        req_last[i]           = b[W];
        req_data[i*W +: W]    = b[W-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*W +: W]    = '0;
      end
    end
  endtask

  task automatic push_frame(input int src, input int len, input logic [W-1:0] base);
    for (int k = 0; k < len; k++) sq[src].push_back({k == len - 1, base + W'(k)});
  endtask

  // One clock cycle: observe at negedge, retire accepted beats at posedge,
  // present the next beats just after it.
  task automatic step();
    @(negedge clk);
    cyc++;
    obs_w_en  = fifo_w_en;
    obs_data  = fifo_data;
    obs_ready = req_ready;
    obs_busy  = busy;
    obs_gid   = grant_id;
    obs_abort = abort;
    if (obs_w_en) begin
      got_q.push_back(obs_data);
      wr_cyc_q.push_back(cyc);
    end
    if (obs_busy && !prev_busy) gnt_q.push_back(int'(obs_gid));
    prev_busy = obs_busy;
    if (obs_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && obs_ready[i]) void'(sq[i].pop_front());
    #1;
    drive();
  endtask

  // Reference: frames are served whole, in rotation starting after the last
  // served source, skipping sources with nothing queued.
  task automatic model_schedule();
    logic [W:0] mq [N][$];
    logic [W:0] b;
    int         s, left;
    bit         got;
    for (int i = 0; i < N; i++) mq[i] = sq[i];
    left = pending();
    while (left > 0) begin
      s   = 0;
      got = 0;
      for (int k = 1; k <= N; k++)
        if (!got && mq[(model_last + k) % N].size() > 0) begin
          s   = (model_last + k) % N;
          got = 1;
        end
      do begin
        b = mq[s].pop_front();
        exp_q.push_back(b[W-1:0]);
        left--;
      end while (!b[W]);
      exp_gnt.push_back(s);
      model_last = s;
    end
  endtask

  task automatic apply_reset();
    srstn = 1'b0;
    for (int i = 0; i < N; i++) sq[i].delete();
    hold = '0; fifo_full = 1'b0;
    exp_q.delete(); got_q.delete(); exp_gnt.delete(); gnt_q.delete(); wr_cyc_q.delete();
    abort_cnt = 0; abort_cyc = -1; model_last = N - 1;
    drive();
    step();
    step();
    srstn = 1'b1;
  endtask

  task automatic run_until_drained(input int max, input string name);
    int n = 0;
    while ((pending() > 0 || obs_busy) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout got=%0d_cycles exp=<%0d", name, n, max);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", obs_busy); end
    checks++; if (obs_w_en !== 1'b0) begin failures++; $display("FAIL reset_w_en got=%0b exp=0", obs_w_en); end
    checks++; if (obs_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    checks++; if (obs_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%0b exp=0", obs_abort); end
    checks++; if (obs_gid !== '0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", obs_gid); end
  endtask

  task automatic test_reset_priority();
    int s;
    int offs[6] = '{2, 3, 4, 6, 7, 8};
    apply_reset();
    push_frame(0, 3, 8'h11);
    push_frame(2, 3, 8'h21);
    model_schedule();
    drive();
    s = cyc;
    run_until_drained(40, "prio");
    checks++;
    if (got_q.size() != 6 || wr_cyc_q.size() != 6) begin
      failures++; $display("FAIL prio_count got=%0d exp=6", got_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL prio_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
        checks++;
        if (wr_cyc_q[k] - s != offs[k]) begin failures++; $display("FAIL prio_timing[%0d] got=%0d exp=%0d", k, wr_cyc_q[k] - s, offs[k]); end
      end
    end
    checks++;
    if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 2) begin
      failures++; $display("FAIL prio_grants got=%p exp=0,2", gnt_q);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_frame(i, 1, W'(i * 16 + r));
    model_schedule();
    drive();
    run_until_drained(100, "fair");
    checks++;
    if (gnt_q.size() != exp_gnt.size()) begin
      failures++; $display("FAIL fair_grant_count got=%0d exp=%0d", gnt_q.size(), exp_gnt.size());
    end else begin
      for (int k = 0; k < gnt_q.size(); k++) begin
        checks++;
        if (gnt_q[k] != exp_gnt[k] || (k < 6 && gnt_q[k] != k % N)) begin
          failures++; $display("FAIL fair_grant[%0d] got=%0d exp=%0d", k, gnt_q[k], exp_gnt[k]);
        end
      end
    end
    checks++;
    if (got_q != exp_q) begin failures++; $display("FAIL fair_data got=%p exp=%p", got_q, exp_q); end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    push_frame(0, 4, 8'h41);
    push_frame(3, 1, 8'h5a);
    model_schedule();
    drive();
    step();
    step();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (obs_w_en !== 1'b0 || obs_ready !== '0 || obs_busy !== 1'b1 || obs_gid !== '0 || obs_abort !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=w_en%0b/ready%b/busy%0b/gid%0d/abort%0b exp=0/0000/1/0/0",
                 k, obs_w_en, obs_ready, obs_busy, obs_gid, obs_abort);
      end
    end
    fifo_full = 1'b0;
    run_until_drained(40, "bp");
    checks++;
    if (got_q != exp_q) begin failures++; $display("FAIL bp_data got=%p exp=%p", got_q, exp_q); end
    checks++;
    if (gnt_q != exp_gnt) begin failures++; $display("FAIL bp_grants got=%p exp=%p", gnt_q, exp_gnt); end
  endtask

  task automatic test_stall_timeout();
    int t;
    apply_reset();
    push_frame(0, 4, 8'h61);
    push_frame(1, 1, 8'h71);
    drive();
    step(); step(); step();
    t = cyc;
    hold[0] = 1'b1;
    drive();
    for (int k = 0; k < 30; k++) step();
    checks++;
    if (abort_cnt != 1) begin failures++; $display("FAIL stall_abort_count got=%0d exp=1", abort_cnt); end
    checks++;
    if (abort_cyc != t + SMAX + 1) begin failures++; $display("FAIL stall_abort_time got=%0d exp=%0d", abort_cyc - t, SMAX + 1); end
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 8'h61 || got_q[1] !== 8'h62 || got_q[2] !== 8'h71) begin
      failures++; $display("FAIL stall_data got=%p exp=61,62,71", got_q);
    end
    checks++;
    if (gnt_q.size() != 2 || gnt_q[0] != 0 || gnt_q[1] != 1) begin
      failures++; $display("FAIL stall_grants got=%p exp=0,1", gnt_q);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    push_frame(0, 1, 8'ha0);
    push_frame(1, 5, 8'h91);
    drive();
    for (int k = 0; k < 5; k++) step();
    srstn = 1'b0;
    push_frame(0, 1, 8'h81);
    drive();
    step();
    srstn = 1'b1;
    step();
    checks++;
    if (obs_busy !== 1'b0 || obs_w_en !== 1'b0 || obs_ready !== '0) begin
      failures++; $display("FAIL mrst_idle got=busy%0b/w_en%0b/ready%b exp=0/0/0000", obs_busy, obs_w_en, obs_ready);
    end
    step();
    checks++;
    if (obs_busy !== 1'b1 || obs_gid !== '0 || obs_w_en !== 1'b1 || obs_data !== 8'h81) begin
      failures++; $display("FAIL mrst_priority got=busy%0b/gid%0d/w_en%0b/data%h exp=1/0/1/81", obs_busy, obs_gid, obs_w_en, obs_data);
    end
  endtask

  task automatic test_random();
    int len;
    int n = 0;
    apply_reset();
    for (int i = 0; i < N; i++)
      for (int f = $urandom_range(0, 3); f > 0; f--) begin
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) sq[i].push_back({k == len - 1, W'($urandom)});
      end
    if (pending() == 0) push_frame(2, 2, W'($urandom));
    model_schedule();
    drive();
    while ((pending() > 0 || obs_busy) && n < 2000) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
      n++;
      checks++;
      if ($countones(obs_ready) > 1 || (fifo_full && (obs_w_en || obs_ready != '0))) begin
        failures++; $display("FAIL rand_ready got=ready%b/w_en%0b full=%0b exp=onehot0_and_blocked", obs_ready, obs_w_en, fifo_full);
      end
    end
    fifo_full = 1'b0;
    checks++;
    if (n >= 2000) begin failures++; $display("FAIL rand_timeout got=%0d exp=<2000", n); end
    checks++;
    if (got_q != exp_q) begin failures++; $display("FAIL rand_data got=%0d_beats exp=%0d_beats", got_q.size(), exp_q.size()); end
    checks++;
    if (gnt_q != exp_gnt) begin failures++; $display("FAIL rand_grants got=%p exp=%p", gnt_q, exp_gnt); end
  endtask

  initial begin
    srstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; hold = '0;
    cyc = 0; checks = 0; failures = 0; abort_cnt = 0; abort_cyc = -1; model_last = N - 1;
    prev_busy = 1'b0; obs_busy = 1'b0;
    test_reset();
    test_reset_priority();
    test_fairness();
    test_back_pressure();
    test_stall_timeout();
    test_mid_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
